// File: rtl/led_sched_pkg.sv
// Shared types, constants and pattern tables for the LED pattern scheduler.
//   mode_e        : displayed pattern (IDLE / SWEEP / BLINK)
//   SWEEP_CODE    : DIP code that selects the sweep pattern
//   OFF_CODE      : DIP code that selects the idle (all-off) state
//   pattern_bits  : (mode, step) -> logical LED value, 1 = lit
//   last_step     : final step index of a pattern
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    BLINK = 2'b10
  } mode_e;

  localparam logic [3:0]  SWEEP_CODE = 4'b0110;
  localparam logic [3:0]  OFF_CODE   = 4'b0000;

  localparam int unsigned SWEEP_LEN  = 8;
  localparam int unsigned BLINK_LEN  = 6;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned LED_W      = 4;
  localparam int unsigned DIP_W      = 4;

  // Final step index of a pattern; IDLE has no steps.
  function automatic logic [STEP_W-1:0] last_step(input mode_e m);
    logic [STEP_W-1:0] res;
    res = '0;
    case (m)
      SWEEP:   res = STEP_W'(SWEEP_LEN - 1);
      BLINK:   res = STEP_W'(BLINK_LEN - 1);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Logical LED value (1 = lit) for a given pattern step.
  function automatic logic [LED_W-1:0] pattern_bits(input mode_e m,
                                                    input logic [STEP_W-1:0] s);
    logic [LED_W-1:0] res;
    res = '0;
    case (m)
      SWEEP: begin
        case (s)
          3'd0:    res = 4'b0001;
          3'd1:    res = 4'b0010;
          3'd2:    res = 4'b0100;
          3'd3:    res = 4'b1000;
          3'd4:    res = 4'b0100;
          3'd5:    res = 4'b0010;
          3'd6:    res = 4'b0001;
          default: res = 4'b0000;
        endcase
      end
      // Even steps dark, odd steps fully lit.
      BLINK:   res = s[0] ? 4'b1111 : 4'b0000;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_pattern_scheduler_if.sv
// Board-side signal bundle of the LED pattern scheduler.
//   dip      : raw DIP switches (asynchronous to clk)
//   led      : LED pin levels
//   mode     : current pattern (00 IDLE, 01 SWEEP, 10 BLINK)
//   step     : step index within the current pattern
//   pat_done : one-cycle pulse on a pattern boundary
// master = board/environment side, slave = scheduler side.
interface led_pattern_scheduler_if;
  import led_sched_pkg::*;

  logic [DIP_W-1:0]  dip;
  logic [LED_W-1:0]  led;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step;
  logic              pat_done;

  modport master (
    output dip,
    input  led,
    input  mode,
    input  step,
    input  pat_done
  );

  modport slave (
    input  dip,
    output led,
    output mode,
    output step,
    output pat_done
  );

endinterface

// File: rtl/led_dip_debounce.sv
// DIP switch synchronizer and tick-based debouncer.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : sampling strobe from the prescaler
//   dip_raw    : raw DIP switches, asynchronous to clk
//   dip_deb    : debounced DIP value, registered
// A new value is accepted once DEB_TICKS consecutive tick samples agree.
module led_dip_debounce #(
  parameter int unsigned DEB_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] dip_raw,
  output logic [3:0] dip_deb
);

  localparam int unsigned RUN_W = $clog2(DEB_TICKS + 1);

  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       cand;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt_c;

  // Length of the run of equal samples including the current one; saturates.
  always_comb begin
    run_nxt_c = RUN_W'(1);
    if (sync2 == cand) begin
      if (run == RUN_W'(DEB_TICKS)) begin
        run_nxt_c = run;
      end else begin
        run_nxt_c = run + RUN_W'(1);
      end
    end
  end

  // Two-flop synchronizer plus run tracking on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      run     <= '0;
      dip_deb <= '0;
    end else begin
      sync1 <= dip_raw;
      sync2 <= sync1;
      if (tick) begin
        cand <= sync2;
        run  <= run_nxt_c;
        if (run_nxt_c >= RUN_W'(DEB_TICKS)) begin
          dip_deb <= sync2;
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// LED pattern scheduler for the 4-LED bank.
//   clk, rst_n : 48 MHz clock, asynchronous active-low reset
//   bus        : board-side bundle (dip in; led, mode, step, pat_done out)
// A prescaler produces the step tick. Patterns advance one step per tick and
// the next pattern is chosen from the debounced DIP only at a pattern
// boundary; after SWEEP_REPEAT consecutive sweeps a blink pass is forced.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 4800000,
  parameter int unsigned SWEEP_REPEAT   = 2,
  parameter int unsigned DEB_TICKS      = 2,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_pattern_scheduler_if.slave bus
);

  localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(SWEEP_REPEAT + 1);
  localparam logic [LED_W-1:0] LED_OFF = LED_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [PS_W-1:0]   ps_cnt;
  logic              tick_c;
  logic [DIP_W-1:0]  dip_deb;

  mode_e             mode_q,     mode_d;
  logic [STEP_W-1:0] step_q,     step_d;
  logic [CNT_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic [LED_W-1:0]  led_q,      led_d;
  logic              pat_done_q, pat_done_d;

  mode_e             dec_mode_c;
  logic [CNT_W-1:0]  dec_cnt_c;

  // Logical pattern value to pin level.
  function automatic logic [LED_W-1:0] to_pin(input logic [LED_W-1:0] lit);
    return LED_ACTIVE_LOW ? ~lit : lit;
  endfunction

  // Step tick prescaler: one-cycle tick at count TICK_DIV-1, then wrap.
  assign tick_c = (ps_cnt == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick_c) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  led_dip_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick_c),
    .dip_raw (bus.dip),
    .dip_deb (dip_deb)
  );

  // Next-pattern decision from the debounced DIP and the sweep run count.
  always_comb begin
    dec_mode_c = IDLE;
    dec_cnt_c  = '0;
    if (dip_deb == OFF_CODE) begin
      dec_mode_c = IDLE;
      dec_cnt_c  = '0;
    end else if ((dip_deb == SWEEP_CODE) &&
                 (sweep_cnt_q < CNT_W'(SWEEP_REPEAT))) begin
      dec_mode_c = SWEEP;
      dec_cnt_c  = sweep_cnt_q + CNT_W'(1);
    end else begin
      // Other codes, or the forced interlude after a full sweep run.
      dec_mode_c = BLINK;
      dec_cnt_c  = '0;
    end
  end

  // Pattern FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= IDLE;
      step_q      <= '0;
      sweep_cnt_q <= '0;
      led_q       <= LED_OFF;
      pat_done_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      step_q      <= step_d;
      sweep_cnt_q <= sweep_cnt_d;
      led_q       <= led_d;
      pat_done_q  <= pat_done_d;
    end
  end

  // Pattern FSM next state; everything holds between ticks.
  always_comb begin
    mode_d      = mode_q;
    step_d      = step_q;
    sweep_cnt_d = sweep_cnt_q;
    led_d       = led_q;
    pat_done_d  = 1'b0;
    if (tick_c) begin
      case (mode_q)
        IDLE: begin
          mode_d      = dec_mode_c;
          sweep_cnt_d = dec_cnt_c;
          step_d      = '0;
          led_d       = to_pin(pattern_bits(dec_mode_c, '0));
        end
        SWEEP, BLINK: begin
          if (step_q < last_step(mode_q)) begin
            step_d = step_q + STEP_W'(1);
            led_d  = to_pin(pattern_bits(mode_q, step_q + STEP_W'(1)));
          end else begin
            // Boundary: the decision sees the debounced DIP held before this edge.
            pat_done_d  = 1'b1;
            mode_d      = dec_mode_c;
            sweep_cnt_d = dec_cnt_c;
            step_d      = '0;
            led_d       = to_pin(pattern_bits(dec_mode_c, '0));
          end
        end
        default: begin
          mode_d      = IDLE;
          step_d      = '0;
          sweep_cnt_d = '0;
          led_d       = LED_OFF;
        end
      endcase
    end
  end

  assign bus.led      = led_q;
  assign bus.mode     = mode_q;
  assign bus.step     = step_q;
  assign bus.pat_done = pat_done_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Self-checking bench for led_pattern_scheduler (TICK_DIV=4, SWEEP_REPEAT=2,
// DEB_TICKS=2, active-low LEDs). Expected per-tick outputs are queued as the
// DIP stimulus is driven and compared on each tick edge; between ticks the
// outputs must hold with pat_done low.
module tb_led_pattern_scheduler;

  localparam int unsigned TICK_DIV = 4;

  typedef struct packed {
    logic [3:0] led;
    logic [1:0] mode;
    logic [2:0] step;
    logic       pd;
  } exp_t;

  localparam exp_t IDLE_EXP = '{led: 4'b1111, mode: 2'b00, step: 3'd0, pd: 1'b0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_pattern_scheduler_if bus();

  led_pattern_scheduler #(
    .TICK_DIV       (TICK_DIV),
    .SWEEP_REPEAT   (2),
    .DEB_TICKS      (2),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        last_exp = IDLE_EXP;
  int unsigned n_vec    = 0;
  int unsigned n_err    = 0;
  int unsigned clk_cnt  = 0;
  logic [3:0]  dip_now  = 4'b0000;
  logic [3:0]  sw_led [8];
  logic [3:0]  bl_led [6];
  event        tick_ev;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    check_eq({tag, ".led"},  32'(bus.led),      32'(e.led));
    check_eq({tag, ".mode"}, 32'(bus.mode),     32'(e.mode));
    check_eq({tag, ".step"}, 32'(bus.step),     32'(e.step));
    check_eq({tag, ".pd"},   32'(bus.pat_done), 32'(e.pd));
  endtask

  // Drive the DIP for the coming tick and queue what that tick must show.
  task automatic drive_tick(input exp_t e);
    bus.dip = dip_now;
    exp_q.push_back(e);
    @(tick_ev);
    #2;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(IDLE_EXP);
  endtask

  task automatic sweep_pass(input logic pd0, input int chg_at, input logic [3:0] chg_val);
    for (int s = 0; s < 8; s++) begin
      if (s == chg_at) dip_now = chg_val;
      drive_tick('{led: sw_led[s], mode: 2'b01, step: 3'(s),
                   pd: (s == 0) ? pd0 : 1'b0});
    end
  endtask

  task automatic blink_pass(input logic pd0, input int n);
    for (int s = 0; s < n; s++) begin
      drive_tick('{led: bl_led[s], mode: 2'b10, step: 3'(s),
                   pd: (s == 0) ? pd0 : 1'b0});
    end
  endtask

  // Monitor: tick edges every TICK_DIV clocks after reset release.
  initial begin
    exp_t e;
    logic is_tick;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        clk_cnt = 0;
      end else begin
        clk_cnt++;
        is_tick = ((clk_cnt % TICK_DIV) == 0);
        if (is_tick) -> tick_ev;
        #1;
        if (is_tick) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            compare_out("tick", e);
            last_exp = e;
          end
        end else begin
          compare_out("hold", '{led: last_exp.led, mode: last_exp.mode,
                                 step: last_exp.step, pd: 1'b0});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sw_led[0] = 4'b1110; sw_led[1] = 4'b1101; sw_led[2] = 4'b1011; sw_led[3] = 4'b0111;
    sw_led[4] = 4'b1011; sw_led[5] = 4'b1101; sw_led[6] = 4'b1110; sw_led[7] = 4'b1111;
    bl_led[0] = 4'b1111; bl_led[1] = 4'b0000; bl_led[2] = 4'b1111;
    bl_led[3] = 4'b0000; bl_led[4] = 4'b1111; bl_led[5] = 4'b0000;

    bus.dip = 4'b0000;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_out("rst", IDLE_EXP);
    @(negedge clk);
    rst_n = 1'b1;

    // 20 idle ticks, with a one-tick 0110 glitch that must be rejected.
    dip_now = 4'b0000;
    idle_ticks(4);
    dip_now = 4'b0110;
    idle_ticks(1);
    dip_now = 4'b0000;
    idle_ticks(15);

    // Sweep selected: two ticks of debounce/decision latency, then two sweeps,
    // the forced blink, and a third sweep during which the DIP changes.
    dip_now = 4'b0110;
    idle_ticks(2);
    sweep_pass(1'b0, 8, 4'b0000);
    sweep_pass(1'b1, 8, 4'b0000);
    blink_pass(1'b1, 6);
    sweep_pass(1'b1, 4, 4'b0001);
    blink_pass(1'b1, 6);
    blink_pass(1'b1, 4);

    // Asynchronous reset at blink step 3: outputs clear without a clock edge.
    #3;
    rst_n    = 1'b0;
    last_exp = IDLE_EXP;
    #1;
    compare_out("arst", IDLE_EXP);
    dip_now = 4'b0110;
    bus.dip = dip_now;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sweep run count restarts: two full sweeps before the interlude.
    idle_ticks(2);
    sweep_pass(1'b0, 8, 4'b0000);
    sweep_pass(1'b1, 8, 4'b0000);
    blink_pass(1'b1, 6);
    sweep_pass(1'b1, 8, 4'b0000);

    #20;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
